// File: rtl/sys_ctrl.sv
// sys_ctrl: command sequencer between the UART RX byte stream, the register
// file, the ALU and the UART TX FIFO. Every output is a register; strobes are
// single-cycle pulses that clear themselves by default on the following edge.
module sys_ctrl #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 4,
   parameter int ALU_OUT_WIDTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [DATA_WIDTH-1:0]    i_rx_data,
   input  logic                     i_rx_valid,
   output logic [ADDR_WIDTH-1:0]    o_rf_addr,
   output logic                     o_rf_wr_en,
   output logic [DATA_WIDTH-1:0]    o_rf_wr_data,
   output logic                     o_rf_rd_en,
   input  logic [DATA_WIDTH-1:0]    i_rf_rd_data,
   input  logic                     i_rf_rd_valid,
   output logic                     o_alu_en,
   output logic [3:0]               o_alu_func,
   input  logic [ALU_OUT_WIDTH-1:0] i_alu_out,
   input  logic                     i_alu_valid,
   output logic                     o_clk_gate_en,
   output logic [DATA_WIDTH-1:0]    o_tx_data,
   output logic                     o_tx_valid,
   input  logic                     i_tx_full,
   output logic                     o_busy
);

   localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);

   typedef enum logic [3:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      WR_EXEC,
      RD_ADDR,
      RD_REQ,
      RD_WAIT,
      OP_A,
      OP_B,
      ALU_FUNC,
      ALU_REQ,
      ALU_WAIT,
      TX_LO,
      TX_HI
   } state_t;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   result_hi;
   logic                    send_hi;

   // Sequencer: decodes command bytes, issues one-cycle strobes and serialises
   // read data / ALU results into the TX FIFO. The TX strobe is raised the
   // cycle after the FIFO is seen non-full, and the state only advances once
   // that strobe has been issued, so each byte goes out exactly once.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state         <= IDLE;
         result_hi     <= '0;
         send_hi       <= 1'b0;
         o_rf_addr     <= '0;
         o_rf_wr_en    <= 1'b0;
         o_rf_wr_data  <= '0;
         o_rf_rd_en    <= 1'b0;
         o_alu_en      <= 1'b0;
         o_alu_func    <= '0;
         o_clk_gate_en <= 1'b0;
         o_tx_data     <= '0;
         o_tx_valid    <= 1'b0;
         o_busy        <= 1'b0;
      end else begin
         o_rf_wr_en <= 1'b0;
         o_rf_rd_en <= 1'b0;
         o_alu_en   <= 1'b0;
         o_tx_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (i_rx_valid) begin
                  if (i_rx_data == CMD_WR) begin
                     state  <= WR_ADDR;
                     o_busy <= 1'b1;
                  end else if (i_rx_data == CMD_RD) begin
                     state  <= RD_ADDR;
                     o_busy <= 1'b1;
                  end else if (i_rx_data == CMD_ALU_OP) begin
                     state         <= OP_A;
                     o_busy        <= 1'b1;
                     o_clk_gate_en <= 1'b1;
                  end else if (i_rx_data == CMD_ALU) begin
                     state         <= ALU_FUNC;
                     o_busy        <= 1'b1;
                     o_clk_gate_en <= 1'b1;
                  end
               end
            end

            WR_ADDR: begin
               if (i_rx_valid) begin
                  o_rf_addr <= i_rx_data[ADDR_WIDTH-1:0];
                  state     <= WR_DATA;
               end
            end

            WR_DATA: begin
               if (i_rx_valid) begin
                  o_rf_wr_data <= i_rx_data;
                  o_rf_wr_en   <= 1'b1;
                  state        <= WR_EXEC;
               end
            end

            WR_EXEC: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end

            RD_ADDR: begin
               if (i_rx_valid) begin
                  o_rf_addr  <= i_rx_data[ADDR_WIDTH-1:0];
                  o_rf_rd_en <= 1'b1;
                  state      <= RD_REQ;
               end
            end

            RD_REQ, RD_WAIT: begin
               if (i_rf_rd_valid) begin
                  o_tx_data <= i_rf_rd_data;
                  send_hi   <= 1'b0;
                  state     <= TX_LO;
               end else begin
                  state <= RD_WAIT;
               end
            end

            OP_A: begin
               if (i_rx_valid) begin
                  o_rf_addr    <= '0;
                  o_rf_wr_data <= i_rx_data;
                  o_rf_wr_en   <= 1'b1;
                  state        <= OP_B;
               end
            end

            OP_B: begin
               if (i_rx_valid) begin
                  o_rf_addr    <= ADDR_WIDTH'(1);
                  o_rf_wr_data <= i_rx_data;
                  o_rf_wr_en   <= 1'b1;
                  state        <= ALU_FUNC;
               end
            end

            ALU_FUNC: begin
               if (i_rx_valid) begin
                  o_alu_func <= i_rx_data[3:0];
                  o_alu_en   <= 1'b1;
                  state      <= ALU_REQ;
               end
            end

            ALU_REQ, ALU_WAIT: begin
               if (i_alu_valid) begin
                  o_tx_data     <= i_alu_out[DATA_WIDTH-1:0];
                  result_hi     <= i_alu_out[ALU_OUT_WIDTH-1:DATA_WIDTH];
                  send_hi       <= 1'b1;
                  o_clk_gate_en <= 1'b0;
                  state         <= TX_LO;
               end else begin
                  state <= ALU_WAIT;
               end
            end

            TX_LO: begin
               if (o_tx_valid) begin
                  if (send_hi) begin
                     o_tx_data <= result_hi;
                     state     <= TX_HI;
                  end else begin
                     state  <= IDLE;
                     o_busy <= 1'b0;
                  end
               end else if (!i_tx_full) begin
                  o_tx_valid <= 1'b1;
               end
            end

            TX_HI: begin
               if (o_tx_valid) begin
                  send_hi <= 1'b0;
                  state   <= IDLE;
                  o_busy  <= 1'b0;
               end else if (!i_tx_full) begin
                  o_tx_valid <= 1'b1;
               end
            end

            default: begin
               state         <= IDLE;
               o_busy        <= 1'b0;
               o_clk_gate_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sys_ctrl.sv
// tb_sys_ctrl: drives command byte streams into sys_ctrl, plays the part of
// the register file, ALU and TX FIFO, and compares observed strobes and TX
// bytes against a transaction-level model of the command protocol.
module tb_sys_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [7:0]  i_rx_data;
   logic        i_rx_valid;
   logic [3:0]  o_rf_addr;
   logic        o_rf_wr_en;
   logic [7:0]  o_rf_wr_data;
   logic        o_rf_rd_en;
   logic [7:0]  i_rf_rd_data;
   logic        i_rf_rd_valid;
   logic        o_alu_en;
   logic [3:0]  o_alu_func;
   logic [15:0] i_alu_out;
   logic        i_alu_valid;
   logic        o_clk_gate_en;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        i_tx_full;
   logic        o_busy;

   sys_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_OUT_WIDTH(16)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_rx_data     (i_rx_data),
      .i_rx_valid    (i_rx_valid),
      .o_rf_addr     (o_rf_addr),
      .o_rf_wr_en    (o_rf_wr_en),
      .o_rf_wr_data  (o_rf_wr_data),
      .o_rf_rd_en    (o_rf_rd_en),
      .i_rf_rd_data  (i_rf_rd_data),
      .i_rf_rd_valid (i_rf_rd_valid),
      .o_alu_en      (o_alu_en),
      .o_alu_func    (o_alu_func),
      .i_alu_out     (i_alu_out),
      .i_alu_valid   (i_alu_valid),
      .o_clk_gate_en (o_clk_gate_en),
      .o_tx_data     (o_tx_data),
      .o_tx_valid    (o_tx_valid),
      .i_tx_full     (i_tx_full),
      .o_busy        (o_busy)
   );

   // Free-running reference clock
   always #5 i_clk = ~i_clk;

   typedef struct {
      int         nb;
      logic [7:0] b [4];
      int         rd_dly;
      int         alu_dly;
      int         exp_nwr;
      int         exp_ntx;
      logic [7:0] tx0;
      logic [7:0] tx1;
   } vec_t;

   int tests = 0;
   int fails = 0;
   int rd_dly = 0;
   int alu_dly = 1;
   int gate_idle_cnt = 0;
   int gate_tx_cnt = 0;

   logic [7:0]  rf_mem [16];
   logic [7:0]  model_mem [16];
   logic [11:0] act_wr [$];
   logic [11:0] exp_wr [$];
   logic [3:0]  act_rd [$];
   logic [3:0]  exp_rd [$];
   logic [3:0]  act_alu [$];
   logic [3:0]  exp_alu [$];
   logic [7:0]  act_tx [$];
   logic [7:0]  exp_tx [$];

   // Behaviour of the external ALU; both the stand-in ALU and the model use it
   function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
      case (f)
         4'd0:    return 16'(a) + 16'(b);
         4'd1:    return 16'(a) - 16'(b);
         4'd2:    return 16'(a) * 16'(b);
         4'd3:    return {8'h00, a & b};
         default: return {a, b};
      endcase
   endfunction

   function automatic vec_t mk(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3, input int rd,
                               input int alu, input int nwr, input int ntx,
                               input logic [7:0] t0, input logic [7:0] t1);
      vec_t v;
      v.nb = nb;
      v.b[0] = b0;
      v.b[1] = b1;
      v.b[2] = b2;
      v.b[3] = b3;
      v.rd_dly = rd;
      v.alu_dly = alu;
      v.exp_nwr = nwr;
      v.exp_ntx = ntx;
      v.tx0 = t0;
      v.tx1 = t1;
      return v;
   endfunction

   // Observe DUT strobes mid-cycle and log each one as a transaction
   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (o_rf_wr_en) begin
            act_wr.push_back({o_rf_addr, o_rf_wr_data});
            rf_mem[o_rf_addr] <= o_rf_wr_data;
         end
         if (o_rf_rd_en) act_rd.push_back(o_rf_addr);
         if (o_alu_en) act_alu.push_back(o_alu_func);
         if (o_tx_valid) act_tx.push_back(o_tx_data);
         if (o_clk_gate_en && !o_busy) gate_idle_cnt <= gate_idle_cnt + 1;
         if (o_clk_gate_en && o_tx_valid) gate_tx_cnt <= gate_tx_cnt + 1;
      end
   end

   // Register-file and ALU stand-ins answering strobes after a programmable delay
   initial begin : responder
      int         rd_cnt;
      int         alu_cnt;
      bit         rd_pend;
      bit         alu_pend;
      logic [3:0] rd_a;
      logic [3:0] alu_f;
      rd_cnt = 0;
      alu_cnt = 0;
      rd_pend = 1'b0;
      alu_pend = 1'b0;
      rd_a = '0;
      alu_f = '0;
      i_rf_rd_valid = 1'b0;
      i_rf_rd_data = '0;
      i_alu_valid = 1'b0;
      i_alu_out = '0;
      forever begin
         @(negedge i_clk);
         i_rf_rd_valid = 1'b0;
         i_alu_valid = 1'b0;
         if (i_rst) begin
            rd_pend = 1'b0;
            alu_pend = 1'b0;
         end else begin
            if (o_rf_rd_en) begin
               rd_pend = 1'b1;
               rd_cnt = rd_dly;
               rd_a = o_rf_addr;
            end
            if (o_alu_en) begin
               alu_pend = 1'b1;
               alu_cnt = alu_dly;
               alu_f = o_alu_func;
            end
            if (rd_pend) begin
               if (rd_cnt == 0) begin
                  i_rf_rd_valid = 1'b1;
                  i_rf_rd_data = rf_mem[rd_a];
                  rd_pend = 1'b0;
               end else begin
                  rd_cnt--;
               end
            end
            if (alu_pend) begin
               if (alu_cnt == 0) begin
                  i_alu_valid = 1'b1;
                  i_alu_out = alu_ref(alu_f, rf_mem[0], rf_mem[1]);
                  alu_pend = 1'b0;
               end else begin
                  alu_cnt--;
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge i_clk);
      i_rx_data = b;
      i_rx_valid = 1'b1;
      @(negedge i_clk);
      i_rx_valid = 1'b0;
      repeat (2) @(negedge i_clk);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (o_busy && n < budget) begin
         @(negedge i_clk);
         n++;
      end
      checkOutput("busy_cleared", 32'(o_busy), 32'd0);
   endtask

   task automatic model_alu(input logic [7:0] f);
      logic [15:0] r;
      r = alu_ref(f[3:0], model_mem[0], model_mem[1]);
      exp_alu.push_back(f[3:0]);
      exp_tx.push_back(r[7:0]);
      exp_tx.push_back(r[15:8]);
   endtask

   // Protocol-level prediction of the transactions a command produces
   task automatic model_cmd(input vec_t v);
      case (v.b[0])
         8'hAA: begin
            exp_wr.push_back({v.b[1][3:0], v.b[2]});
            model_mem[v.b[1][3:0]] = v.b[2];
         end
         8'hBB: begin
            exp_rd.push_back(v.b[1][3:0]);
            exp_tx.push_back(model_mem[v.b[1][3:0]]);
         end
         8'hCC: begin
            exp_wr.push_back({4'h0, v.b[1]});
            exp_wr.push_back({4'h1, v.b[2]});
            model_mem[0] = v.b[1];
            model_mem[1] = v.b[2];
            model_alu(v.b[3]);
         end
         8'hDD: model_alu(v.b[1]);
         default: ;
      endcase
   endtask

   task automatic compare_events();
      checkOutput("wr_count", 32'(act_wr.size()), 32'(exp_wr.size()));
      while (act_wr.size() > 0 && exp_wr.size() > 0)
         checkOutput("wr_addr_data", 32'(act_wr.pop_front()), 32'(exp_wr.pop_front()));
      checkOutput("rd_count", 32'(act_rd.size()), 32'(exp_rd.size()));
      while (act_rd.size() > 0 && exp_rd.size() > 0)
         checkOutput("rd_addr", 32'(act_rd.pop_front()), 32'(exp_rd.pop_front()));
      checkOutput("alu_count", 32'(act_alu.size()), 32'(exp_alu.size()));
      while (act_alu.size() > 0 && exp_alu.size() > 0)
         checkOutput("alu_func", 32'(act_alu.pop_front()), 32'(exp_alu.pop_front()));
      checkOutput("tx_count", 32'(act_tx.size()), 32'(exp_tx.size()));
      while (act_tx.size() > 0 && exp_tx.size() > 0)
         checkOutput("tx_byte", 32'(act_tx.pop_front()), 32'(exp_tx.pop_front()));
      act_wr.delete();
      exp_wr.delete();
      act_rd.delete();
      exp_rd.delete();
      act_alu.delete();
      exp_alu.delete();
      act_tx.delete();
      exp_tx.delete();
   endtask

   task automatic applyStimulus(input vec_t v, input bit use_tbl);
      int g_idle;
      int g_tx;
      g_idle = gate_idle_cnt;
      g_tx = gate_tx_cnt;
      rd_dly = v.rd_dly;
      alu_dly = v.alu_dly;
      model_cmd(v);
      for (int i = 0; i < v.nb; i++) begin
         send_byte(v.b[i]);
         if (i == 0 && (v.b[0] == 8'hCC || v.b[0] == 8'hDD))
            checkOutput("gate_on", 32'(o_clk_gate_en), 32'd1);
      end
      wait_idle(500);
      repeat (2) @(negedge i_clk);
      if (use_tbl) begin
         checkOutput("tbl_nwr", 32'(act_wr.size()), 32'(v.exp_nwr));
         checkOutput("tbl_ntx", 32'(act_tx.size()), 32'(v.exp_ntx));
         if (v.exp_ntx >= 1 && act_tx.size() >= 1) checkOutput("tbl_tx0", 32'(act_tx[0]), 32'(v.tx0));
         if (v.exp_ntx >= 2 && act_tx.size() >= 2) checkOutput("tbl_tx1", 32'(act_tx[1]), 32'(v.tx1));
      end
      compare_events();
      checkOutput("gate_while_idle", 32'(gate_idle_cnt - g_idle), 32'd0);
      checkOutput("gate_during_tx", 32'(gate_tx_cnt - g_tx), 32'd0);
      checkOutput("gate_off", 32'(o_clk_gate_en), 32'd0);
   endtask

   function automatic logic [31:0] all_outputs();
      return 32'({o_rf_addr, o_rf_wr_en, o_rf_wr_data, o_rf_rd_en, o_alu_en, o_alu_func,
                  o_clk_gate_en, o_tx_data, o_tx_valid, o_busy});
   endfunction

   initial begin : stimulus
      vec_t tbl [11];
      vec_t v;
      int   kind;
      logic [7:0] junk;

      tbl[0]  = mk(3, 8'hAA, 8'h04, 8'h8F, 8'h00, 0, 1, 1, 0, 8'h00, 8'h00);
      tbl[1]  = mk(2, 8'hBB, 8'h04, 8'h00, 8'h00, 2, 1, 0, 1, 8'h8F, 8'h00);
      tbl[2]  = mk(4, 8'hCC, 8'h64, 8'h32, 8'h00, 0, 3, 2, 2, 8'h96, 8'h00);
      tbl[3]  = mk(1, 8'h55, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 8'h00);
      tbl[4]  = mk(2, 8'hDD, 8'h01, 8'h00, 8'h00, 0, 1, 0, 2, 8'h32, 8'h00);
      tbl[5]  = mk(3, 8'hAA, 8'h1F, 8'h3C, 8'h00, 0, 1, 1, 0, 8'h00, 8'h00);
      tbl[6]  = mk(2, 8'hBB, 8'hFF, 8'h00, 8'h00, 0, 1, 0, 1, 8'h3C, 8'h00);
      tbl[7]  = mk(2, 8'hDD, 8'h02, 8'h00, 8'h00, 0, 4, 0, 2, 8'h88, 8'h13);
      tbl[8]  = mk(2, 8'hBB, 8'h00, 8'h00, 8'h00, 5, 1, 0, 1, 8'h64, 8'h00);
      tbl[9]  = mk(4, 8'hCC, 8'hFF, 8'h02, 8'h01, 0, 2, 2, 2, 8'hFD, 8'h00);
      tbl[10] = mk(2, 8'hDD, 8'h03, 8'h00, 8'h00, 0, 0, 0, 2, 8'h02, 8'h00);

      for (int i = 0; i < 16; i++) begin
         rf_mem[i] = '0;
         model_mem[i] = '0;
      end
      i_rst = 1'b1;
      i_rx_data = '0;
      i_rx_valid = 1'b0;
      i_tx_full = 1'b0;
      repeat (3) @(negedge i_clk);
      checkOutput("reset_outputs", all_outputs(), 32'd0);
      i_rst = 1'b0;
      repeat (2) @(negedge i_clk);

      for (int i = 0; i < 11; i++) applyStimulus(tbl[i], 1'b1);

      // TX FIFO full for a long stretch: nothing may leave until it drains
      v = mk(2, 8'hDD, 8'h01, 8'h00, 8'h00, 0, 2, 0, 2, 8'hFD, 8'h00);
      alu_dly = v.alu_dly;
      model_cmd(v);
      i_tx_full = 1'b1;
      send_byte(8'hDD);
      send_byte(8'h01);
      repeat (14) @(negedge i_clk);
      checkOutput("stall_no_tx", 32'(act_tx.size()), 32'd0);
      checkOutput("stall_busy", 32'(o_busy), 32'd1);
      i_tx_full = 1'b0;
      wait_idle(100);
      repeat (2) @(negedge i_clk);
      checkOutput("stall_tx0", 32'(act_tx.size() > 0 ? act_tx[0] : 8'hxx), 32'h00FD);
      compare_events();

      // Bytes arriving while the ALU is busy must be dropped
      v = mk(2, 8'hDD, 8'h00, 8'h00, 8'h00, 0, 12, 0, 2, 8'h00, 8'h00);
      alu_dly = v.alu_dly;
      model_cmd(v);
      send_byte(8'hDD);
      send_byte(8'h00);
      send_byte(8'hAA);
      send_byte(8'hBB);
      wait_idle(100);
      repeat (2) @(negedge i_clk);
      compare_events();

      // Reset in the middle of a write command
      send_byte(8'hAA);
      send_byte(8'h07);
      @(negedge i_clk);
      i_rst = 1'b1;
      #1;
      checkOutput("midrst_outputs", all_outputs(), 32'd0);
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      repeat (2) @(negedge i_clk);
      checkOutput("midrst_no_wr", 32'(act_wr.size()), 32'd0);
      applyStimulus(mk(2, 8'hBB, 8'h07, 8'h00, 8'h00, 1, 1, 0, 1, 8'h00, 8'h00), 1'b1);

      // Randomised command mix checked against the protocol model
      for (int n = 0; n < 40; n++) begin
         kind = int'($urandom_range(0, 4));
         v = mk(1, 8'h00, 8'($urandom), 8'($urandom), 8'($urandom_range(0, 15)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), 0, 0, 8'h00, 8'h00);
         case (kind)
            0: begin v.b[0] = 8'hAA; v.nb = 3; end
            1: begin v.b[0] = 8'hBB; v.nb = 2; end
            2: begin v.b[0] = 8'hCC; v.nb = 4; end
            3: begin v.b[0] = 8'hDD; v.nb = 2; v.b[1] = 8'($urandom_range(0, 15)); end
            default: begin
               junk = 8'($urandom);
               if (junk == 8'hAA || junk == 8'hBB || junk == 8'hCC || junk == 8'hDD) junk = 8'h00;
               v.b[0] = junk;
               v.nb = 1;
            end
         endcase
         applyStimulus(v, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sys_ctrl.md
# sys_ctrl

- Command sequencer between the UART receive path, register file, ALU and UART transmit FIFO.
- Decodes the byte-oriented command protocol:
  - 0xAA: register write
  - 0xBB: register read
  - 0xCC: ALU op with operands
  - 0xDD: ALU op without operands
- Drives register-file and ALU strobes and the ALU clock-gate enable.
- Returns read data and ALU results to the TX FIFO as bytes.
- Sits in the reference-clock domain; the UART byte stream arrives already synchronized.

## Interface

- DATA_WIDTH, 8, byte width of RX/TX and register file data
- ADDR_WIDTH, 4, register file address width
- ALU_OUT_WIDTH, 16, ALU result width (2 × DATA_WIDTH)

Clock and reset (already decided): one clock, `i_clk`; reset `i_rst` is asynchronous and active-high.

- i_clk  in  1  system (reference) clock
- i_rst  in  1  asynchronous, active-high reset
- i_rx_data  in  DATA_WIDTH  received byte
- i_rx_valid  in  1  one-cycle pulse per received byte
- o_rf_addr  out  ADDR_WIDTH  register file address
- o_rf_wr_en  out  1  register file write strobe
- o_rf_wr_data  out  DATA_WIDTH  register file write data
- o_rf_rd_en  out  1  register file read strobe
- i_rf_rd_data  in  DATA_WIDTH  register file read data
- i_rf_rd_valid  in  1  read data valid
- o_alu_en  out  1  ALU start strobe
- o_alu_func  out  4  ALU function select
- i_alu_out  in  ALU_OUT_WIDTH  ALU result
- i_alu_valid  in  1  ALU result valid
- o_clk_gate_en  out  1  ALU clock-gate enable
- o_tx_data  out  DATA_WIDTH  byte to TX FIFO
- o_tx_valid  out  1  TX FIFO write strobe
- i_tx_full  in  1  TX FIFO full
- o_busy  out  1  high whenever not IDLE

## Operation

- States: IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_REQ, RD_WAIT, OP_A, OP_B, ALU_FUNC, ALU_REQ, ALU_WAIT, TX_LO, TX_HI.
- All outputs are registered (Moore). On reset:
  - every output is 0; state is IDLE
  - internal byte registers are cleared
- IDLE, on an accepted byte:
  - 0xAA → WR_ADDR
  - 0xBB → RD_ADDR
  - 0xCC → OP_A
  - 0xDD → ALU_FUNC
  - any other value is discarded; stay IDLE
- Write (0xAA):
  - WR_ADDR captures `i_rx_data[ADDR_WIDTH-1:0]`; upper bits are ignored.
  - WR_DATA captures the data byte, then goes to WR_EXEC.
  - WR_EXEC asserts `o_rf_wr_en` for 1 cycle with the captured address and data, then → IDLE.
- Read (0xBB):
  - RD_ADDR captures the address.
  - RD_REQ asserts `o_rf_rd_en` for 1 cycle.
  - RD_WAIT holds until `i_rf_rd_valid`, capturing `i_rf_rd_data`, then → TX_LO.
  - In this path TX_LO sends only the read byte, then → IDLE.
- ALU with operands (0xCC):
  - OP_A: on the accepted byte, write it to address 0x0 (one-cycle `o_rf_wr_en`, same timing as WR_EXEC), then → OP_B.
  - OP_B: write the accepted byte to 0x1, then → ALU_FUNC.
- ALU_FUNC:
  - Captures `i_rx_data[3:0]` into `o_alu_func`.
  - ALU_REQ asserts `o_alu_en` for 1 cycle.
  - ALU_WAIT captures `i_alu_out` on `i_alu_valid`, then → TX_LO.
- ALU result transmit: TX_LO sends `result[7:0]`, TX_HI sends `result[15:8]`, then → IDLE.
- `o_clk_gate_en` is high in OP_A, OP_B, ALU_FUNC, ALU_REQ and ALU_WAIT; low elsewhere.
- A byte arriving in RD_REQ, RD_WAIT, ALU_REQ, ALU_WAIT, WR_EXEC, TX_LO or TX_HI is dropped. The command in flight continues.

## Timing

- A byte is accepted at the rising edge where `i_rx_valid` = 1 in a byte-expecting state.
- Write latency: `o_rf_wr_en` is high in the cycle immediately after the data-byte accept edge, for exactly 1 cycle.
- The operand writes for OP_A and OP_B overlap the wait for the next byte, so no accept is lost.
- Read: `o_rf_rd_en` is high the cycle after the address accept.
  - `i_rf_rd_valid` may arrive the same cycle as, or any number of cycles after, the read strobe.
- ALU: `o_alu_en` is high the cycle after the function accept; there is no timeout waiting for `i_alu_valid`.
- TX handshake:
  - In TX_LO/TX_HI, `o_tx_valid` pulses for 1 cycle, in the first cycle that `i_tx_full` = 0.
  - `o_tx_data` is stable from state entry.
  - While `i_tx_full` = 1 the state holds and `o_tx_valid` = 0. No byte is ever duplicated or lost.
- Back-to-back commands: the next command byte may be accepted in the first IDLE cycle after the previous command completes.
- Reset asserted mid-command:
  - all strobes drop asynchronously
  - no partial register write or TX byte is issued
  - the controller returns to IDLE

## Test plan

- Write 0xAA, 0x04, 0x8F → exactly one `o_rf_wr_en` pulse with addr 0x4, data 0x8F; back to IDLE; `o_busy` low.
- Read 0xBB, 0x04 with `i_rf_rd_data` = 0x8F after 2 cycles → `o_rf_rd_en` pulse with addr 0x4; one `o_tx_valid` pulse with 0x8F.
- ALU with operands 0xCC, 0x64, 0x32, 0x00, with `i_alu_out` = 0x0096 →
  - writes 0x0←0x64 and 0x1←0x32
  - `o_alu_en` pulse with func 0
  - TX bytes 0x96 then 0x00
  - `o_clk_gate_en` high from the 0xCC accept until TX_LO
- ALU without operands 0xDD, 0x01 with `i_tx_full` held high for 10 cycles → `o_tx_valid` stays 0 during the stall, then exactly two pulses (low byte, high byte).
- Unknown and dropped bytes:
  - 0x55 in IDLE → no strobes; still IDLE.
  - A byte injected during ALU_WAIT → ignored; the result is still sent correctly.
- Reset mid-operation: assert `i_rst` after 0xAA, 0x07 and before the data byte → all outputs 0; the subsequent 0xBB, 0x07 read proceeds normally.
